pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Program-counter and next-PC stage for the MIPS32 datapath. It consumes the 32-bit sign-extended immediate and forms branch targets as PC+4 + (imm<<2). It also handles J/JAL and JR targets, and drives a req/ready fetch handshake to instruction memory. It holds the architectural PC register, a fetch state machine, a misaligned-JR fault latch and a retired-fetch counter.

Parameters:
RESET_VECTOR, 32'h0040_0000, PC value loaded on reset (must be word-aligned)
CNT_W, 32, width of retired-fetch counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imm_ext  input  32  sign-extended 16-bit immediate of the current instruction
branch_en  input  1  current instruction is BEQ/BNE class
branch_cond  input  1  branch condition true (from ALU zero logic)
jump_en  input  1  current instruction is J/JAL
jump_target  input  26  instr[25:0]
jr_en  input  1  current instruction is JR/JALR
jr_addr  input  32  rs register value
stall  input  1  hold current instruction; no PC update
imem_ready  input  1  instruction word valid this cycle
imem_req  output  1  fetch request to instruction memory at address pc
pc  output  32  current PC
pc_plus4  output  32  pc + 4, for JAL link and branch base
fetch_valid  output  1  instruction at pc completes this cycle
misaligned  output  1  sticky JR alignment fault
fetch_count  output  CNT_W  number of completed fetches

Behaviour:
- Reset is asynchronous and active-high: rst=1 immediately forces pc=RESET_VECTOR, state=BOOT, misaligned=0, fetch_count=0. imem_req=0 and fetch_valid=0 while in reset.
- pc_plus4 = pc + 4, combinational, mod 2^32 (32'hFFFF_FFFC -> 0).
- States:
  - BOOT: imem_req=0; one cycle after rst deasserts, go to FETCH.
  - FETCH: imem_req=1.
    - imem_ready=0: stay, pc held, fetch_valid=0.
    - imem_ready=1 and stall=1: fetch_valid=0, pc held, stay in FETCH. Request remains asserted and the same address is re-presented.
    - imem_ready=1 and stall=0: fetch_valid=1 this cycle; at the clock edge, pc <= next_pc and fetch_count increments (wraps at 2^CNT_W).
  - FAULT: imem_req=0, fetch_valid=0, misaligned=1, pc frozen. Exit only by rst.
- next_pc priority, evaluated on completing cycle controls:
  1. jr_en: jr_addr. If jr_addr[1:0]!=0, go to FAULT instead; pc is not updated and the count does not increment. fetch_valid is still 1 for that cycle.
  2. jump_en: {pc_plus4[31:28], jump_target, 2'b00}.
  3. branch_en & branch_cond: pc_plus4 + {imm_ext[29:0], 2'b00}, mod 2^32.
  4. otherwise: pc_plus4.
- Multiple enables set at once: the priority above resolves them; no error is raised.
- branch_en=1 with branch_cond=0 behaves as sequential.
- Control inputs are ignored when the cycle is not a completing cycle.
- Latency: one completed fetch per cycle when imem_ready=1 and stall=0. A taken branch or jump has zero bubble; the new pc is presented on the next cycle.
- rst asserted mid-wait (FETCH with imem_ready=0) aborts immediately. There is no completion pulse, and the count is unchanged apart from resetting to 0.
- All outputs are registered except pc_plus4, imem_req and fetch_valid, which are decoded from state and inputs.

Test Plan:
- Reset/boot: pulse rst, imem_ready=1 constant.
  - Required: pc=32'h0040_0000 and imem_req=0 for one cycle.
  - Then the pc sequence is 0040_0000, 0040_0004, 0040_0008, and fetch_count=3 after 3 completions.
- Backward branch: at pc=32'h0040_0010, branch_en=1, branch_cond=1, imm_ext=32'hFFFF_FFFB.
  - Required: next pc=32'h0040_0000.
  - Repeat with branch_cond=0: required next pc=32'h0040_0014.
- Jump vs branch priority: pc=32'h1000_0000, jump_en=1, jump_target=26'h000_0040, branch_en=1, branch_cond=1.
  - Required: next pc=32'h1000_0100.
- Wait and stall: imem_ready low 3 cycles, then high with stall=1 for 2 cycles, then stall=0.
  - Required: pc unchanged and fetch_valid=0 for 5 cycles, then a single fetch_valid pulse and pc+4.
- JR fault: jr_addr=32'h0040_0022.
  - Required: misaligned=1, imem_req=0, pc frozen, fetch_count unchanged.
  - Required: rst clears the fault and pc returns to RESET_VECTOR.
- Wrap-around: force the pc sequence up to 32'hFFFF_FFFC via JR with jr_addr=32'hFFFF_FFFC, then run sequentially.
  - Required: next pc=32'h0000_0000 and no fault.

Source files
------------

// File: rtl/pc_branch_unit.sv
// MIPS32 program counter and next-PC stage: branch/jump/JR target selection,
// req/ready instruction fetch handshake, sticky JR misalignment fault and fetch counter.
module pc_branch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      imm_ext,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic             jump_en,
  input  logic [25:0]      jump_target,
  input  logic             jr_en,
  input  logic [31:0]      jr_addr,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StFetch, StFault} state_t;

  state_t      state;
  logic [31:0] branch_target;
  logic [31:0] jump_addr;
  logic [31:0] next_pc;
  logic        jr_bad;

  assign pc_plus4      = pc + 32'd4;
  // Immediate is already sign-extended; the shift drops its top two bits.
  assign branch_target = pc_plus4 + (imm_ext << 2);
  assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};
  assign jr_bad        = jr_en & (jr_addr[1:0] != 2'b00);

  assign imem_req      = (state == StFetch);
  assign fetch_valid   = imem_req & imem_ready & ~stall;

  always_comb begin
    next_pc = pc_plus4;
    if (jr_en) begin
      next_pc = jr_addr;
    end else if (jump_en) begin
      next_pc = jump_addr;
    end else if (branch_en && branch_cond) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StBoot;
      pc          <= RESET_VECTOR;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        StBoot: begin
          state <= StFetch;
        end
        StFetch: begin
          if (fetch_valid) begin
            // A misaligned JR still completes its fetch but freezes pc and count.
            if (jr_bad) begin
              state      <= StFault;
              misaligned <= 1'b1;
            end else begin
              pc          <= next_pc;
              fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        StFault: begin
          misaligned <= 1'b1;
        end
        default: begin
          state <= StBoot;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized scoreboard bench for pc_branch_unit: driver pushes predicted completions,
// monitor pops them whenever fetch_valid is seen.
module tb_pc_branch_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imm_ext = '0;
  logic        branch_en = 1'b0, branch_cond = 1'b0, jump_en = 1'b0, jr_en = 1'b0;
  logic [25:0] jump_target = '0;
  logic [31:0] jr_addr = '0;
  logic        stall = 1'b0, imem_ready = 1'b0;
  logic        imem_req, fetch_valid, misaligned;
  logic [31:0] pc, pc_plus4, fetch_count;

  pc_branch_unit #(.RESET_VECTOR(RV), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imm_ext(imm_ext), .branch_en(branch_en),
    .branch_cond(branch_cond), .jump_en(jump_en), .jump_target(jump_target),
    .jr_en(jr_en), .jr_addr(jr_addr), .stall(stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [31:0] pc; logic [31:0] cnt; } txn_t;
  txn_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc, m_cnt;
  bit          m_boot, m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected completion per observed fetch_valid
  always @(negedge clk) begin
    if (!rst && fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetch_valid", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        check("sb_pc", pc, t.pc);
        check("sb_count", fetch_count, t.cnt);
      end
    end
  end

  // Called at posedge+1; returns at next posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    {branch_en, branch_cond, jump_en, jr_en, stall, imem_ready} = '0;
    #1;
    check("rst_pc", pc, RV);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = RV; m_cnt = 0; m_boot = 1; m_fault = 0;
  endtask

  task automatic cycle(input bit rdy, input bit st, input bit be, input bit bc,
                       input bit je, input logic [25:0] jt, input bit jre,
                       input logic [31:0] ja, input logic [31:0] imm);
    bit          req, done;
    logic [31:0] p4;
    imem_ready = rdy; stall = st; branch_en = be; branch_cond = bc;
    jump_en = je; jump_target = jt; jr_en = jre; jr_addr = ja; imm_ext = imm;
    req  = !m_boot && !m_fault;
    done = req && rdy && !st;
    p4   = m_pc + 32'd4;
    if (done) exp_q.push_back('{pc: m_pc, cnt: m_cnt});
    @(negedge clk);
    check("req", {31'd0, imem_req}, {31'd0, req});
    check("valid", {31'd0, fetch_valid}, {31'd0, done});
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, p4);
    check("mis", {31'd0, misaligned}, {31'd0, m_fault});
    check("count", fetch_count, m_cnt);
    if (done) begin
      if (jre && ja % 4 != 0) begin
        m_fault = 1;
      end else begin
        if (jre)           m_pc = ja;
        else if (je)       m_pc = {p4[31:28], jt, 2'b00};
        else if (be && bc) m_pc = p4 + imm * 4;
        else               m_pc = p4;
        m_cnt = m_cnt + 1;
      end
    end
    m_boot = 0;
    @(posedge clk); #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, '0, 0, '0, '0);
  endtask

  initial begin
    logic [31:0] r, r2;
    repeat (2) @(posedge clk);
    #1;
    // Reset / boot, sequential fetch
    do_reset();
    seq(4);               // boot cycle + 3 completions
    check("boot_count3", fetch_count, 32'd3);
    check("boot_pc", pc, 32'h0040_000C);
    seq(1);               // pc = 0x0040_0010
    check("pc_at_10", pc, 32'h0040_0010);
    // Backward branch taken then not taken
    cycle(1, 0, 1, 1, 0, '0, 0, '0, 32'hFFFF_FFFB);
    check("bbranch_taken", pc, 32'h0040_0000);
    cycle(1, 0, 0, 0, 0, '0, 1, 32'h0040_0010, '0);
    cycle(1, 0, 1, 0, 0, '0, 0, '0, 32'hFFFF_FFFB);
    check("bbranch_not", pc, 32'h0040_0014);
    // Jump beats branch
    cycle(1, 0, 0, 0, 0, '0, 1, 32'h1000_0000, '0);
    cycle(1, 0, 1, 1, 1, 26'h000_0040, 0, '0, 32'h0000_0010);
    check("jump_prio", pc, 32'h1000_0100);
    // Wait 3, stall 2, then complete
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 1, 26'h3, 0, '0, '0);
    for (int i = 0; i < 2; i++) cycle(1, 1, 1, 1, 1, 26'h3, 0, '0, '0);
    check("stall_pc", pc, 32'h1000_0100);
    seq(1);
    check("stall_done", pc, 32'h1000_0104);
    // Misaligned JR
    r = fetch_count;
    cycle(1, 0, 0, 0, 0, '0, 1, 32'h0040_0022, '0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, '0, 1, 32'h0040_0000, '0);
    check("fault_mis", {31'd0, misaligned}, 32'd1);
    check("fault_pc", pc, 32'h1000_0104);
    check("fault_count", fetch_count, r);
    do_reset();
    check("fault_cleared_pc", pc, RV);
    // Wrap-around
    seq(1);
    cycle(1, 0, 0, 0, 0, '0, 1, 32'hFFFF_FFFC, '0);
    check("wrap_pc_top", pc, 32'hFFFF_FFFC);
    seq(1);
    check("wrap_pc_zero", pc, 32'h0000_0000);
    check("wrap_no_fault", {31'd0, misaligned}, 32'd0);
    // Reset mid-wait
    cycle(0, 0, 0, 0, 0, '0, 0, '0, '0);
    do_reset();
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      r2 = $urandom;
      if (m_fault && r[3:0] == 0) begin
        do_reset();
      end else begin
        cycle(r[4] | r[5], r[6] & r[7], r[8], r[9], r[10] & r[11], r2[25:0],
              r[12] & r[13] & r[14],
              (r[15:12] == 0) ? r2 : {r2[31:2], 2'b00}, $urandom);
      end
    end
    seq(1);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
